// File: rtl/fmul_pipe.sv
// Three-stage pipelined floating-point multiplier with RNE rounding, special-value
// handling, exception flags and a pass-through tag, under a valid/ready handshake.
module fmul_pipe #(
    parameter int unsigned EW = 8,
    parameter int unsigned MW = 23,
    parameter int unsigned TW = 5
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [EW+MW:0]  x1,
    input  logic [EW+MW:0]  x2,
    input  logic [TW-1:0]   in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [EW+MW:0]  y,
    output logic [TW-1:0]   out_tag,
    output logic            ovf,
    output logic            unf,
    output logic            inv
);
    localparam int unsigned FW   = 1 + EW + MW;
    localparam int unsigned PW   = 2 * MW + 2;
    localparam int unsigned XW   = EW + 2;
    localparam int unsigned RW   = MW + 1;
    localparam int unsigned BIAS = (1 << (EW - 1)) - 1;
    localparam int unsigned EMAX = (1 << EW) - 1;
    localparam logic [FW-1:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Stage 1 combinational: unpack, classify, full mantissa product, biased exponent sum
    logic [EW-1:0]        e1, e2;
    logic [MW-1:0]        m1, m2;
    logic                 nan1, nan2, inf1, inf2, zero1, zero2;
    logic                 c1_inv, c1_inf, c1_zero, c1_sign;
    logic [PW-1:0]        c1_prod;
    logic signed [XW-1:0] c1_exp;

    always_comb begin
        e1      = x1[EW+MW-1:MW];
        e2      = x2[EW+MW-1:MW];
        m1      = x1[MW-1:0];
        m2      = x2[MW-1:0];
        zero1   = (e1 == '0);
        zero2   = (e2 == '0);
        inf1    = (&e1) && (m1 == '0);
        inf2    = (&e2) && (m2 == '0);
        nan1    = (&e1) && (m1 != '0);
        nan2    = (&e2) && (m2 != '0);
        c1_inv  = nan1 || nan2 || (inf1 && zero2) || (inf2 && zero1);
        c1_inf  = inf1 || inf2;
        c1_zero = zero1 || zero2;
        c1_sign = x1[FW-1] ^ x2[FW-1];
        c1_prod = PW'({1'b1, m1}) * PW'({1'b1, m2});
        c1_exp  = $signed(XW'(e1)) + $signed(XW'(e2)) - $signed(XW'(BIAS));
    end

    logic                 s1_valid, s1_sign, s1_inv, s1_inf, s1_zero;
    logic [PW-1:0]        s1_prod;
    logic signed [XW-1:0] s1_exp;
    logic [TW-1:0]        s1_tag;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_inv   <= 1'b0;
            s1_inf   <= 1'b0;
            s1_zero  <= 1'b0;
            s1_prod  <= '0;
            s1_exp   <= '0;
            s1_tag   <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign <= c1_sign;
                s1_inv  <= c1_inv;
                s1_inf  <= c1_inf;
                s1_zero <= c1_zero;
                s1_prod <= c1_prod;
                s1_exp  <= c1_exp;
                s1_tag  <= in_tag;
            end
        end
    end

    // Stage 2 combinational: normalise product into [1,2) and extract guard/sticky
    logic [MW-1:0]        c2_man;
    logic                 c2_g, c2_s;
    logic signed [XW-1:0] c2_exp;

    always_comb begin
        c2_exp = s1_exp;
        c2_man = s1_prod[PW-3 -: MW];
        c2_g   = s1_prod[MW-1];
        c2_s   = |s1_prod[MW-2:0];
        if (s1_prod[PW-1]) begin
            c2_exp = s1_exp + $signed(XW'(1));
            c2_man = s1_prod[PW-2 -: MW];
            c2_g   = s1_prod[MW];
            c2_s   = |s1_prod[MW-1:0];
        end
    end

    logic                 s2_valid, s2_sign, s2_inv, s2_inf, s2_zero, s2_g, s2_s;
    logic [MW-1:0]        s2_man;
    logic signed [XW-1:0] s2_exp;
    logic [TW-1:0]        s2_tag;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_inv   <= 1'b0;
            s2_inf   <= 1'b0;
            s2_zero  <= 1'b0;
            s2_g     <= 1'b0;
            s2_s     <= 1'b0;
            s2_man   <= '0;
            s2_exp   <= '0;
            s2_tag   <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sign <= s1_sign;
                s2_inv  <= s1_inv;
                s2_inf  <= s1_inf;
                s2_zero <= s1_zero;
                s2_g    <= c2_g;
                s2_s    <= c2_s;
                s2_man  <= c2_man;
                s2_exp  <= c2_exp;
                s2_tag  <= s1_tag;
            end
        end
    end

    // Stage 3 combinational: round to nearest even, then apply result priority
    logic                 round_up;
    logic [RW-1:0]        rnd;
    logic signed [XW-1:0] c3_exp;
    logic [FW-1:0]        c3_y;
    logic                 c3_ovf, c3_unf, c3_inv;

    always_comb begin
        round_up = s2_g && (s2_s || s2_man[0]);
        rnd      = {1'b0, s2_man} + RW'(round_up);
        // a carry out leaves the mantissa field all-zero, i.e. already renormalised
        c3_exp   = s2_exp + $signed(XW'(rnd[MW]));
        c3_y     = {s2_sign, c3_exp[EW-1:0], rnd[MW-1:0]};
        c3_ovf   = 1'b0;
        c3_unf   = 1'b0;
        c3_inv   = 1'b0;
        if (s2_inv) begin
            c3_y   = QNAN;
            c3_inv = 1'b1;
        end else if (s2_inf) begin
            c3_y = {s2_sign, {EW{1'b1}}, {MW{1'b0}}};
        end else if (s2_zero) begin
            c3_y = {s2_sign, {(EW+MW){1'b0}}};
        end else if (c3_exp >= $signed(XW'(EMAX))) begin
            c3_y   = {s2_sign, {EW{1'b1}}, {MW{1'b0}}};
            c3_ovf = 1'b1;
        end else if (c3_exp <= $signed(XW'(0))) begin
            c3_y   = {s2_sign, {(EW+MW){1'b0}}};
            c3_unf = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            y         <= '0;
            out_tag   <= '0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            inv       <= 1'b0;
        end else if (adv) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                y       <= c3_y;
                out_tag <= s2_tag;
                ovf     <= c3_ovf;
                unf     <= c3_unf;
                inv     <= c3_inv;
            end
        end
    end

endmodule

// File: doc/fmul_pipe.md
# fmul_pipe

Parametrised, pipelined IEEE-754-style floating-point multiplier for the FPU datapath. It generalises the single-precision combinational multiplier to configurable exponent and mantissa widths. It adds three registered stages with a valid/ready handshake, round-to-nearest-even on the full-width product, and special-value handling (zero, inf, NaN). It also outputs exception flags and passes a tag through so the issue logic can match results to instructions.

## Interface
- `EW`, 8: exponent width; bias = 2^(EW-1)-1.
- `MW`, 23: stored mantissa width; hidden bit implied.
- `TW`, 5: tag width, passed through unchanged.
- `clk` input 1: clock; all state on rising edge.
- `rstn` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operand pair present.
- `in_ready` output 1: pipeline accepts operands this cycle.
- `x1`, `x2` input 1+EW+MW: operands {sign, exp, mantissa}.
- `in_tag` input TW: caller ID.
- `out_valid` output 1: result present.
- `out_ready` input 1: consumer takes result this cycle.
- `y` output 1+EW+MW: product.
- `out_tag` output TW: tag of the result.
- `ovf`, `unf`, `inv` output 1 each: overflow, underflow, invalid flags for the result.

## Operation
- **Stage 1: unpack and classify.**
  - Exponent 0 means zero; denormals are flushed to signed zero.
  - Exponent all-ones with mantissa 0 means inf; with mantissa non-zero it means NaN.
  - Output sign = s1 ^ s2.
  - Mantissa product is the full (MW+1)×(MW+1) result, 2MW+2 bits, with no truncation.
  - Biased exponent sum e1+e2-bias is kept in EW+2 bits, signed.
- **Stage 2: normalise.**
  - If product bit 2MW+1 is set: shift right by 1 and increment the exponent.
  - Derive guard bit G and sticky bit S (OR of all lower bits).
- **Stage 3: round and pack.**
  - Round to nearest even: increment when G & (S | lsb).
  - If the increment carries out of the mantissa, renormalise and increment the exponent again.
- **Result priority** (first match wins):
  - Either operand NaN, or inf×zero: `y` = canonical qNaN {0, all-ones, 1, zeros}; `inv`=1.
  - Either operand inf: `y` = signed inf.
  - Either operand zero: `y` = signed zero, no flags.
  - Final exponent ≥ 2^EW-1: `y` = signed inf; `ovf`=1.
  - Final exponent ≤ 0: `y` = signed zero; `unf`=1.
  - Otherwise: normal packed result.
- Flags apply only to the current `y` and are not sticky.

## Timing
- Latency is exactly 3 cycles from an accepted input to `out_valid` when there is no stall. Throughput is one result per cycle.
- Advance signal: adv = !out_valid | out_ready.
  - When adv=1, all three stages shift together.
  - `in_ready` = adv, purely combinational.
  - An input is accepted when in_valid & in_ready.
- Bubbles (stages holding no valid data) travel down the pipe and are not collapsed.
- When out_valid=1 and out_ready=0:
  - All stages hold their contents.
  - `y`, `out_tag` and the flags stay stable until the result is taken.
- A result is consumed when out_valid & out_ready. An input accepted in the same cycle enters stage 1.
- **Reset:**
  - Every stage's valid bit is cleared, so out_valid=0.
  - `y`=0, `out_tag`=0, `ovf`=`unf`=`inv`=0.
  - `in_ready`=1 immediately.
  - Assertion mid-operation discards all in-flight operations; none is emitted after release.
- Outputs are registered; no combinational path from `x1`/`x2` to `y`.

## Test plan
- **Basic product, EW=8, MW=23:**
  - Stimulus: 0x3FC00000 × 0x40000000.
  - Required: 0x40400000 exactly 3 cycles after acceptance, no flags.
- **RNE ties:**
  - 0x3F800001 × 0x3FC00000 → 0x3FC00002 (tie, odd lsb, round up).
  - 0x3F800003 × 0x3FC00000 → 0x3FC00004 (tie, even lsb, hold).
  - 0x3F800001 × 0x3F800001 → 0x3F800002.
- **Specials:**
  - 0x7F800000 × 0x00000000 → 0x7FC00000 with `inv`=1.
  - 0xFF800000 × 0x40000000 → 0xFF800000.
  - 0x00000001 × 0x3F800000 → 0x00000000 (denormal flushed).
- **Range:**
  - 0x7F000000 × 0x40000000 → 0x7F800000 with `ovf`=1.
  - 0x00800000 × 0x3F000000 → 0x00000000 with `unf`=1.
- **Backpressure:**
  - Stimulus: stream tags 0..7 back-to-back; hold out_ready=0 from cycle 3 to cycle 9.
  - Required: in_ready drops while the head result waits; `y`/`out_tag` stay stable.
  - Required: all 8 results emerge in tag order with none lost or duplicated.
- **Reset mid-stream:**
  - Stimulus: pulse rstn low with 3 operations in flight.
  - Required: out_valid=0 and all outputs zero immediately; the first result after release belongs to the first operation accepted after release.
- **Half precision, EW=5, MW=10:**
  - Stimulus: 0x3E00 × 0x4000.
  - Required: 0x4200.
